reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Eight-entry circular reorder buffer for the out-of-order LC-3b core. It sits between dispatch and the architectural register file. Dispatch allocates entries in program order, and execution units write results over the CDB. Completed entries retire in order into the register file through its load_value/value_in/dest_value port. The buffer also raises flush when a mispredicted branch (destination REGISTER_PC) reaches the head.

## Interface
Parameters: none. Depth is fixed at 8 by lc3b_rob_id.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- alloc_req  in  1  dispatch requests one entry this cycle
- alloc_dest  in  lc3b_ext_reg  architectural destination (0–7, or REGISTER_PC)
- alloc_ready  out  1  entry available and no flush this cycle
- alloc_id  out  lc3b_rob_id  id granted if the allocation fires (tail index)
- cdb_valid  in  1  CDB broadcast this cycle
- cdb_rob_id  in  lc3b_rob_id  producing entry
- cdb_value  in  lc3b_word  result (branch target for PC entries)
- cdb_mispredict  in  1  marks the entry as mispredicted
- src_a_id, src_b_id  in  lc3b_rob_id  operand lookup ids
- src_a_ready, src_b_ready  out  1  value available for the id
- src_a_value, src_b_value  out  lc3b_word  looked-up value
- load_value  out  1  commit strobe to the register file
- dest_value  out  lc3b_ext_reg  commit destination
- value_out  out  lc3b_word  commit data
- commit_id  out  lc3b_rob_id  id of the retiring entry
- flush  out  1  mispredict flush, shared with the register file and reservation stations
- redirect_pc  out  lc3b_word  fetch redirect target, valid with flush
- count  out  4  occupied entries, 0–8

## Operation
- Per-entry state:
  - valid
  - done
  - mispredict
  - dest (lc3b_ext_reg)
  - value (lc3b_word)
- Pointers and count:
  - head and tail are 3-bit and wrap 7→0.
  - count is 4-bit, which separates full (8) from empty (0).
- Allocate: alloc_ready = (count != 8) && !flush. When alloc_req && alloc_ready, the entry at tail is set valid=1, done=0, mispredict=0, dest=alloc_dest, and tail increments. alloc_id = {1'b0, tail}, driven combinationally.
- CDB write: when cdb_valid, cdb_rob_id != REORDER_ID_INVALID, and the target entry is valid, the entry gets value=cdb_value, done=1, mispredict=cdb_mispredict. Writes to invalid entries are dropped.
- Lookup, per port:
  - If id == REORDER_ID_INVALID or the entry is invalid: ready=0, value=0.
  - Otherwise, if the CDB targets the same id this cycle, forward it: ready=1, value=cdb_value.
  - Otherwise: ready = entry.done, value = entry.value.
- Commit: when head is valid && done, load_value=1 with dest_value, value_out and commit_id taken from head. At the clock edge, head increments and the entry is cleared. When not committing, load_value=0 and the other commit outputs are 0.
- Flush: when committing an entry with dest == REGISTER_PC && mispredict, flush=1 and redirect_pc = head value in the same cycle.
  - load_value stays 1 in that cycle; the register file ignores REGISTER_PC writes.
  - At the edge, all entries are invalidated and head, tail and count return to 0.
  - Allocations and CDB writes in that cycle are discarded.
- Count: next count = count + alloc_fire − commit_fire; forced to 0 on flush.
- Reset (asynchronous, active-low): all entries invalid, head=tail=0, count=0. Consequently load_value=0, flush=0, alloc_ready=1, alloc_id=0, and all src ready outputs are 0.

## Timing
- Allocate-to-visible: an entry allocated at edge N can be written by the CDB in cycle N+1.
- Complete-to-commit: a CDB write at edge N to the head entry commits combinationally in cycle N+1; head advances at edge N+1. Minimum latency is 1 cycle from completion to retirement.
- Throughput: at most one allocation and one commit per cycle.
- Full condition: alloc_ready uses the registered count. A full buffer rejects allocation even if a commit happens in the same cycle.
- Combined events: allocate, CDB write and commit may all occur in the same cycle and are independent. When the buffer is empty, head == tail and no commit occurs.
- Flush duration: flush is a single-cycle pulse. alloc_ready rises again in the cycle after the flush.

## Structure
- The package lc3b_types carries the shared types and constants:
  - lc3b_rob_id (4 bits; ids 0–7 valid)
  - REORDER_ID_INVALID = 4'hF
  - lc3b_ext_reg (4 bits; REGISTER_PC = 4'd8)
  - a new lc3b_rob_entry struct {valid, done, mispredict, dest, value}
- macros.sv provides the constants.
- Sub-module rob_lookup: a combinational single-port read with CDB forwarding, instantiated twice.

## Test plan
- Reset, then allocate 8 entries with dests 0–7: alloc_id sequence 0..7, count=8, alloc_ready=0, and a ninth request is ignored.
- CDB writes id 1 with 16'h1234 before id 0: no commit. Then writing id 0 with 16'hBEEF gives two consecutive load_value cycles, with commit_id 0 then 1 and values BEEF then 1234.
- Lookup of id 2 in the same cycle as a CDB write of id 2 with 16'h00AA: src_a_ready=1 and src_a_value=00AA combinationally. A lookup of REORDER_ID_INVALID returns ready=0.
- A PC entry at head is completed with cdb_mispredict=1 and value 16'h3000, with entries behind it plus an alloc_req in the flush cycle: flush=1 and redirect_pc=3000 for one cycle. Next cycle count=0, alloc_id=0, and the discarded alloc is absent.
- Wrap: allocate and commit 12 entries in steady state. Ids wrap 7→0 and commits remain in order.
- Assert reset_n low mid-stream with count=5: all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared LC-3b types and constants for the reorder buffer slice.
//   lc3b_word      : 16-bit datapath word
//   lc3b_rob_id    : 4-bit ROB id; 0-7 name entries, 4'hF means "no producer"
//   lc3b_ext_reg   : 4-bit architectural destination; 0-7 GPRs, 8 is the PC
//   lc3b_rob_entry : per-entry bookkeeping held by the reorder buffer
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [3:0]  lc3b_rob_id;
   typedef logic [3:0]  lc3b_ext_reg;

   localparam lc3b_rob_id  REORDER_ID_INVALID = 4'hF;
   localparam lc3b_ext_reg REGISTER_PC        = 4'd8;
   localparam int          ROB_DEPTH          = 8;

   typedef struct packed {
      logic        valid;
      logic        done;
      logic        mispredict;
      lc3b_ext_reg dest;
      lc3b_word    value;
   } lc3b_rob_entry;

endpackage

// File: rtl/reorder_buffer_lookup.sv
// Single operand lookup port with same-cycle CDB forwarding.
//   id          : ROB id being looked up (REORDER_ID_INVALID = no producer)
//   entry_*     : state of the addressed entry
//   cdb_*       : CDB broadcast of this cycle
//   ready/value : operand availability and value (0 when not ready via entry)
module rob_lookup
   import lc3b_types::*;
(
   input  lc3b_rob_id id,
   input  logic       entry_valid,
   input  logic       entry_done,
   input  lc3b_word   entry_value,
   input  logic       cdb_valid,
   input  lc3b_rob_id cdb_rob_id,
   input  lc3b_word   cdb_value,
   output logic       ready,
   output lc3b_word   value
);

   always_comb begin
      ready = 1'b0;
      value = '0;
      if (id != REORDER_ID_INVALID && entry_valid) begin
         if (cdb_valid && cdb_rob_id == id) begin
            ready = 1'b1;
            value = cdb_value;
         end else begin
            ready = entry_done;
            value = entry_value;
         end
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// Eight-entry circular reorder buffer between dispatch and the register file.
// Dispatch allocates at tail in program order, the CDB completes entries out of
// order, and completed entries retire in order from head. A retiring PC entry
// that was mispredicted raises a one-cycle flush that empties the buffer.
// Ports:
//   clk, reset_n                  : clock, async active-low reset
//   alloc_req/alloc_dest          : dispatch allocation request
//   alloc_ready/alloc_id          : allocation grant and granted id (tail)
//   cdb_valid/rob_id/value/mispr. : completion broadcast
//   src_{a,b}_id -> ready/value   : operand lookups
//   load_value/dest_value/value_out/commit_id : in-order commit to regfile
//   flush/redirect_pc             : mispredict recovery
//   count                         : occupancy 0-8
module reorder_buffer
   import lc3b_types::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        alloc_req,
   input  lc3b_ext_reg alloc_dest,
   output logic        alloc_ready,
   output lc3b_rob_id  alloc_id,
   input  logic        cdb_valid,
   input  lc3b_rob_id  cdb_rob_id,
   input  lc3b_word    cdb_value,
   input  logic        cdb_mispredict,
   input  lc3b_rob_id  src_a_id,
   input  lc3b_rob_id  src_b_id,
   output logic        src_a_ready,
   output logic        src_b_ready,
   output lc3b_word    src_a_value,
   output lc3b_word    src_b_value,
   output logic        load_value,
   output lc3b_ext_reg dest_value,
   output lc3b_word    value_out,
   output lc3b_rob_id  commit_id,
   output logic        flush,
   output lc3b_word    redirect_pc,
   output logic [3:0]  count
);

   lc3b_rob_entry rob [ROB_DEPTH];
   logic [2:0]    head;
   logic [2:0]    tail;
   logic [3:0]    count_q;

   lc3b_rob_entry head_e;
   logic          commit_fire;
   logic          alloc_fire;
   logic          cdb_hit;

   assign head_e      = rob[head];
   assign commit_fire = head_e.valid && head_e.done;
   assign flush       = commit_fire && head_e.mispredict && (head_e.dest == REGISTER_PC);

   // Registered count only: a full buffer stays closed even while committing.
   assign alloc_ready = (count_q != 4'd8) && !flush;
   assign alloc_fire  = alloc_req && alloc_ready;
   assign alloc_id    = {1'b0, tail};
   assign count       = count_q;

   assign cdb_hit = cdb_valid && (cdb_rob_id != REORDER_ID_INVALID) &&
                    rob[cdb_rob_id[2:0]].valid;

   assign load_value  = commit_fire;
   assign dest_value  = commit_fire ? head_e.dest  : '0;
   assign value_out   = commit_fire ? head_e.value : '0;
   assign commit_id   = commit_fire ? {1'b0, head} : '0;
   assign redirect_pc = flush ? head_e.value : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else if (flush) begin
         // Allocations and CDB writes in the flush cycle are dropped here.
         for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         if (cdb_hit) begin
            rob[cdb_rob_id[2:0]].value      <= cdb_value;
            rob[cdb_rob_id[2:0]].done       <= 1'b1;
            rob[cdb_rob_id[2:0]].mispredict <= cdb_mispredict;
         end
         if (commit_fire) begin
            rob[head] <= '0;
            head      <= head + 3'd1;
         end
         // Tail never aliases a valid head here: alloc requires count < 8.
         if (alloc_fire) begin
            rob[tail] <= '{valid: 1'b1, done: 1'b0, mispredict: 1'b0,
                           dest: alloc_dest, value: '0};
            tail      <= tail + 3'd1;
         end
         count_q <= count_q + {3'b0, alloc_fire} - {3'b0, commit_fire};
      end
   end

   rob_lookup u_lookup_a (
      .id          (src_a_id),
      .entry_valid (rob[src_a_id[2:0]].valid),
      .entry_done  (rob[src_a_id[2:0]].done),
      .entry_value (rob[src_a_id[2:0]].value),
      .cdb_valid   (cdb_valid),
      .cdb_rob_id  (cdb_rob_id),
      .cdb_value   (cdb_value),
      .ready       (src_a_ready),
      .value       (src_a_value)
   );

   rob_lookup u_lookup_b (
      .id          (src_b_id),
      .entry_valid (rob[src_b_id[2:0]].valid),
      .entry_done  (rob[src_b_id[2:0]].done),
      .entry_value (rob[src_b_id[2:0]].value),
      .cdb_valid   (cdb_valid),
      .cdb_rob_id  (cdb_rob_id),
      .cdb_value   (cdb_value),
      .ready       (src_b_ready),
      .value       (src_b_value)
   );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill/full, out-of-order completion with
// in-order commit, lookup forwarding, mispredict flush, wrap-around and
// asynchronous reset.
module tb_reorder_buffer;
   import lc3b_types::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        alloc_req;
   lc3b_ext_reg alloc_dest;
   logic        alloc_ready;
   lc3b_rob_id  alloc_id;
   logic        cdb_valid;
   lc3b_rob_id  cdb_rob_id;
   lc3b_word    cdb_value;
   logic        cdb_mispredict;
   lc3b_rob_id  src_a_id, src_b_id;
   logic        src_a_ready, src_b_ready;
   lc3b_word    src_a_value, src_b_value;
   logic        load_value;
   lc3b_ext_reg dest_value;
   lc3b_word    value_out;
   lc3b_rob_id  commit_id;
   logic        flush;
   lc3b_word    redirect_pc;
   logic [3:0]  count;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   reorder_buffer dut (
      .clk(clk), .reset_n(reset_n),
      .alloc_req(alloc_req), .alloc_dest(alloc_dest),
      .alloc_ready(alloc_ready), .alloc_id(alloc_id),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
      .cdb_value(cdb_value), .cdb_mispredict(cdb_mispredict),
      .src_a_id(src_a_id), .src_b_id(src_b_id),
      .src_a_ready(src_a_ready), .src_b_ready(src_b_ready),
      .src_a_value(src_a_value), .src_b_value(src_b_value),
      .load_value(load_value), .dest_value(dest_value),
      .value_out(value_out), .commit_id(commit_id),
      .flush(flush), .redirect_pc(redirect_pc), .count(count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      alloc_req = 1'b0; alloc_dest = '0;
      cdb_valid = 1'b0; cdb_rob_id = REORDER_ID_INVALID; cdb_value = '0; cdb_mispredict = 1'b0;
      src_a_id = REORDER_ID_INVALID; src_b_id = REORDER_ID_INVALID;
      #3;
      chk("rst_count", count, 0);
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_alloc_id", alloc_id, 0);
      chk("rst_load_value", load_value, 0);
      chk("rst_flush", flush, 0);
      chk("rst_src_a_ready", src_a_ready, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Fill all eight entries.
      for (int i = 0; i < 8; i++) begin
         alloc_req = 1'b1; alloc_dest = 4'(i);
         #1;
         chk($sformatf("fill_id%0d", i), alloc_id, i);
         chk($sformatf("fill_ready%0d", i), alloc_ready, 1);
         tick();
      end
      alloc_dest = 4'd3;
      #1;
      chk("full_ready", alloc_ready, 0);
      chk("full_count", count, 8);
      tick();
      alloc_req = 1'b0;
      #1;
      chk("ninth_ignored_count", count, 8);

      // Complete id1 before id0.
      cdb_valid = 1'b1; cdb_rob_id = 4'd1; cdb_value = 16'h1234; src_b_id = 4'd1;
      #1;
      chk("ooo_no_commit", load_value, 0);
      chk("fwd_b_ready", src_b_ready, 1);
      tick();
      cdb_valid = 1'b0;
      #1;
      chk("ooo_no_commit2", load_value, 0);
      chk("done_b_ready", src_b_ready, 1);
      chk("done_b_value", src_b_value, 16'h1234);
      cdb_valid = 1'b1; cdb_rob_id = 4'd0; cdb_value = 16'hBEEF;
      #1;
      chk("id0_write_no_commit", load_value, 0);
      tick();
      cdb_valid = 1'b0;
      #1;
      chk("c0_load", load_value, 1);
      chk("c0_id", commit_id, 0);
      chk("c0_value", value_out, 16'hBEEF);
      chk("c0_dest", dest_value, 0);
      tick();
      chk("c1_load", load_value, 1);
      chk("c1_id", commit_id, 1);
      chk("c1_value", value_out, 16'h1234);
      chk("c1_dest", dest_value, 1);
      chk("c1_count", count, 7);
      tick();
      chk("post_commit_load", load_value, 0);
      chk("post_commit_count", count, 6);

      // Lookup forwarding and invalid id.
      cdb_valid = 1'b1; cdb_rob_id = 4'd2; cdb_value = 16'h00AA;
      src_a_id = 4'd2; src_b_id = REORDER_ID_INVALID;
      #1;
      chk("fwd_a_ready", src_a_ready, 1);
      chk("fwd_a_value", src_a_value, 16'h00AA);
      chk("inv_b_ready", src_b_ready, 0);
      chk("inv_b_value", src_b_value, 0);
      src_b_id = 4'd3;
      #1;
      chk("pending_b_ready", src_b_ready, 0);
      tick();
      cdb_valid = 1'b0;
      #1;
      chk("c2_load", load_value, 1);
      chk("c2_id", commit_id, 2);
      chk("c2_value", value_out, 16'h00AA);
      tick();

      // Async reset mid-stream with count=5 and a commit pending.
      cdb_valid = 1'b1; cdb_rob_id = 4'd3; cdb_value = 16'h5555;
      tick();
      cdb_valid = 1'b0; src_a_id = 4'd3;
      #1;
      chk("pre_rst_count", count, 5);
      chk("pre_rst_load", load_value, 1);
      chk("pre_rst_a_ready", src_a_ready, 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_load", load_value, 0);
      chk("async_rst_alloc_ready", alloc_ready, 1);
      chk("async_rst_alloc_id", alloc_id, 0);
      chk("async_rst_a_ready", src_a_ready, 0);
      chk("async_rst_flush", flush, 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Mispredicted PC entry at head with entries behind it.
      alloc_req = 1'b1; alloc_dest = REGISTER_PC;
      #1;
      chk("pc_alloc_id", alloc_id, 0);
      tick();
      alloc_dest = 4'd1;
      tick();
      alloc_dest = 4'd2;
      tick();
      alloc_req = 1'b0;
      cdb_valid = 1'b1; cdb_rob_id = 4'd0; cdb_value = 16'h3000; cdb_mispredict = 1'b1;
      tick();
      cdb_rob_id = 4'd1; cdb_value = 16'h7777; cdb_mispredict = 1'b0;
      alloc_req = 1'b1; alloc_dest = 4'd5;
      #1;
      chk("flush", flush, 1);
      chk("redirect_pc", redirect_pc, 16'h3000);
      chk("flush_load", load_value, 1);
      chk("flush_dest", dest_value, REGISTER_PC);
      chk("flush_alloc_ready", alloc_ready, 0);
      chk("flush_count", count, 3);
      tick();
      alloc_req = 1'b0; cdb_valid = 1'b0; src_a_id = 4'd1;
      #1;
      chk("post_flush_flush", flush, 0);
      chk("post_flush_count", count, 0);
      chk("post_flush_alloc_id", alloc_id, 0);
      chk("post_flush_alloc_ready", alloc_ready, 1);
      chk("post_flush_a_ready", src_a_ready, 0);
      chk("post_flush_load", load_value, 0);

      // Steady-state wrap: 12 entries allocated, completed and committed.
      for (int i = 0; i < 14; i++) begin
         alloc_req  = (i < 12);
         alloc_dest = 4'(i % 8);
         cdb_valid  = (i >= 1 && i <= 12);
         cdb_rob_id = 4'((i + 7) % 8);
         cdb_value  = 16'(16'h0100 + i - 1);
         #1;
         chk($sformatf("wrap_count%0d", i), count, (i <= 12) ? ((i < 2) ? i : 2) : 1);
         if (i < 12) chk($sformatf("wrap_alloc_id%0d", i), alloc_id, i % 8);
         chk($sformatf("wrap_load%0d", i), load_value, (i >= 2) ? 1 : 0);
         if (i >= 2) begin
            chk($sformatf("wrap_commit_id%0d", i), commit_id, (i - 2) % 8);
            chk($sformatf("wrap_value%0d", i), value_out, 16'h0100 + i - 2);
         end
         tick();
      end
      alloc_req = 1'b0; cdb_valid = 1'b0;
      #1;
      chk("wrap_final_count", count, 0);
      chk("wrap_final_load", load_value, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
